// File: rtl/dpram_pkg.sv
// Shared types and lane helpers for the byte-enabled dual-port RAM.
// Helpers work on a wide fixed-size word; callers cast to their own widths.
package dpram_pkg;

  localparam int MAX_W   = 256;
  localparam int MAX_NB  = 32;
  localparam int LANE_IW = $clog2(MAX_NB);

  typedef logic [MAX_W-1:0]  word_t;
  typedef logic [MAX_NB-1:0] lane_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Take new_w in every lane whose enable bit is set, old_w elsewhere.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input lane_t be, input int byte_w);
    word_t res;
    int    lane;
    res = old_w;
    for (int j = 0; j < MAX_W; j++) begin
      lane = j / byte_w;
      if (lane < MAX_NB) begin
        if (be[lane[LANE_IW-1:0]]) res[j] = new_w[j];
      end
    end
    return res;
  endfunction

  function automatic logic lane_overlap(input lane_t be_a, input lane_t be_b);
    return |(be_a & be_b);
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then hands the RAM
// over to the ports. Reset during the walk restarts it from address 0.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) r_addr <= r_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (&r_addr) w_state_next = RUN;
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    o_busy     = (r_state == CLEAR);
    o_clr_we   = (r_state == CLEAR);
    o_clr_addr = r_addr;
  end

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, A-wins collision merge, cross-port
// same-edge forwarding, optional output register and a post-reset clear.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 10,
  parameter int                BYTE_W         = 8,
  parameter int                OUT_REG        = 0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  localparam int               NB             = DATA_W / BYTE_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  output logic              o_busy,
  input  logic              i_en_a,
  input  logic              i_we_a,
  input  logic [NB-1:0]     i_be_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  input  logic              i_en_b,
  input  logic              i_we_b,
  input  logic [NB-1:0]     i_be_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_rvalid_a,
  output logic              o_rvalid_b,
  output logic              o_collision
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  dpram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign o_busy = w_busy;

  logic              w_acc_a, w_acc_b, w_same, w_coll;
  logic [NB-1:0]     w_be_a, w_be_b;
  logic [DATA_W-1:0] w_old_a, w_old_b, w_mid_a, w_mid_b, w_new_a, w_new_b;
  logic [ADDR_W-1:0] w_ma_addr;
  logic [DATA_W-1:0] w_ma_data;
  logic [NB-1:0]     w_ma_be;

  assign w_acc_a = i_en_a & ~w_busy;
  assign w_acc_b = i_en_b & ~w_busy;
  assign w_be_a  = (w_acc_a & i_we_a) ? i_be_a : '0;
  assign w_be_b  = (w_acc_b & i_we_b) ? i_be_b : '0;
  assign w_same  = (i_addr_a == i_addr_b);
  assign w_coll  = w_same & lane_overlap(lane_t'(w_be_a), lane_t'(w_be_b));

  assign w_old_a = r_mem[i_addr_a];
  assign w_old_b = r_mem[i_addr_b];

  // Apply B's lanes first, then A's, so A wins overlapping lanes in both views.
  assign w_mid_a = DATA_W'(merge_bytes(word_t'(w_old_a), word_t'(i_wdata_b),
                                       lane_t'(w_be_b & {NB{w_same}}), BYTE_W));
  assign w_new_a = DATA_W'(merge_bytes(word_t'(w_mid_a), word_t'(i_wdata_a),
                                       lane_t'(w_be_a), BYTE_W));
  assign w_mid_b = DATA_W'(merge_bytes(word_t'(w_old_b), word_t'(i_wdata_b),
                                       lane_t'(w_be_b), BYTE_W));
  assign w_new_b = DATA_W'(merge_bytes(word_t'(w_mid_b), word_t'(i_wdata_a),
                                       lane_t'(w_be_a & {NB{w_same}}), BYTE_W));

  assign w_ma_addr = w_clr_we ? w_clr_addr : i_addr_a;
  assign w_ma_data = w_clr_we ? CLEAR_VALUE : i_wdata_a;
  assign w_ma_be   = w_clr_we ? {NB{1'b1}} : w_be_a;

  // Port A is written last so it overrides B on a shared address.
  always_ff @(posedge i_clock) begin
    for (int i = 0; i < NB; i++) begin
      if (w_be_b[i]) r_mem[i_addr_b][i*BYTE_W +: BYTE_W] <= i_wdata_b[i*BYTE_W +: BYTE_W];
      if (w_ma_be[i]) r_mem[w_ma_addr][i*BYTE_W +: BYTE_W] <= w_ma_data[i*BYTE_W +: BYTE_W];
    end
  end

  logic [DATA_W-1:0] r_rdata_a, r_rdata_b;
  logic              r_rvalid_a, r_rvalid_b, r_coll;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_coll     <= 1'b0;
    end else begin
      r_rvalid_a <= w_acc_a;
      r_rvalid_b <= w_acc_b;
      r_coll     <= w_coll;
      if (w_acc_a) r_rdata_a <= w_new_a;
      if (w_acc_b) r_rdata_b <= w_new_b;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_rdata2_a, r_rdata2_b;
    logic              r_rvalid2_a, r_rvalid2_b, r_coll2;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_rdata2_a  <= '0;
        r_rdata2_b  <= '0;
        r_rvalid2_a <= 1'b0;
        r_rvalid2_b <= 1'b0;
        r_coll2     <= 1'b0;
      end else begin
        r_rvalid2_a <= r_rvalid_a;
        r_rvalid2_b <= r_rvalid_b;
        r_coll2     <= r_coll;
        if (r_rvalid_a) r_rdata2_a <= r_rdata_a;
        if (r_rvalid_b) r_rdata2_b <= r_rdata_b;
      end
    end

    assign o_rdata_a   = r_rdata2_a;
    assign o_rdata_b   = r_rdata2_b;
    assign o_rvalid_a  = r_rvalid2_a;
    assign o_rvalid_b  = r_rvalid2_b;
    assign o_collision = r_coll2;
  end else begin : g_direct
    assign o_rdata_a   = r_rdata_a;
    assign o_rdata_b   = r_rdata_b;
    assign o_rvalid_a  = r_rvalid_a;
    assign o_rvalid_b  = r_rvalid_b;
    assign o_collision = r_coll;
  end

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be: one instance without and one with the output
// register, both driven by the same stimulus.
module tb_dpram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;

  logic        busy0, rvalid_a0, rvalid_b0, coll0;
  logic [15:0] rdata_a0, rdata_b0;
  logic        busy1, rvalid_a1, rvalid_b1, coll1;
  logic [15:0] rdata_a1, rdata_b1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dpram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .OUT_REG(0),
             .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .o_busy(busy0),
    .i_en_a(en_a), .i_we_a(we_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a),
    .i_en_b(en_b), .i_we_b(we_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b),
    .o_rdata_a(rdata_a0), .o_rdata_b(rdata_b0), .o_rvalid_a(rvalid_a0),
    .o_rvalid_b(rvalid_b0), .o_collision(coll0));

  dpram_be #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .OUT_REG(1),
             .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .o_busy(busy1),
    .i_en_a(en_a), .i_we_a(we_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a),
    .i_en_b(en_b), .i_we_b(we_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b),
    .o_rdata_a(rdata_a1), .o_rdata_b(rdata_b1), .o_rvalid_a(rvalid_a1),
    .o_rvalid_b(rvalid_b1), .o_collision(coll1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one request per port, clock it in, and sample #1 after the edge.
  task automatic access(input logic ea, input logic wa, input logic [1:0] ba,
                        input logic [3:0] aa, input logic [15:0] da,
                        input logic eb, input logic wb, input logic [1:0] bb,
                        input logic [3:0] ab, input logic [15:0] db);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; wdata_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; wdata_b = db;
    @(posedge clk);
    #1;
    $display("t=%0t A:en=%0b we=%0b be=%b a=%0d d=%h -> %h v=%0b | B:en=%0b we=%0b be=%b a=%0d d=%h -> %h v=%0b | col=%0b",
             $time, ea, wa, ba, aa, da, rdata_a0, rvalid_a0,
             eb, wb, bb, ab, db, rdata_b0, rvalid_b0, coll0);
  endtask

  task automatic idle();
    access(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
  endtask

  task automatic wait_clear(input string tag);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (busy0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid_a0 | rvalid_b0 | rvalid_a1 | rvalid_b1) bad = 1'b1;
    end
    $display("t=%0t clear done after %0d cycles", $time, n);
    check({tag, "_len"}, n, 32'd16);
    check({tag, "_rvalid"}, 32'(bad), 32'd0);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    en_a = 0; we_a = 0; be_a = 0; addr_a = 0; wdata_a = 0;
    en_b = 0; we_b = 0; be_b = 0; addr_b = 0; wdata_b = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd1);
    check("rst_rdata_a", 32'(rdata_a0), 32'd0);
    check("rst_rdata_b", 32'(rdata_b0), 32'd0);
    check("rst_rvalid", 32'({rvalid_a0, rvalid_b0}), 32'd0);
    check("rst_coll", 32'(coll0), 32'd0);

    // Requests held during the clear must be ignored.
    en_a = 1; we_a = 1; be_a = 2'b11; addr_a = 4'd2; wdata_a = 16'hFFFF;
    en_b = 1; we_b = 0; addr_b = 4'd2;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clear("clr1");
    en_a = 0; en_b = 0; we_a = 0;

    for (int i = 0; i < 16; i++) begin
      access(1, 0, 2'b00, 4'(i), 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
      check($sformatf("clr_rd%0d", i), 32'(rdata_a0), 32'h0000A5A5);
      check($sformatf("clr_rv%0d", i), 32'(rvalid_a0), 32'd1);
    end
    idle();
    check("idle_rvalid", 32'(rvalid_a0), 32'd0);
    check("idle_hold", 32'(rdata_a0), 32'h0000A5A5);

    // Byte-lane writes, write-first readback, later cross-port read.
    access(1, 1, 2'b11, 4'd3, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0);
    check("bw_full", 32'(rdata_a0), 32'h00001234);
    access(1, 1, 2'b10, 4'd3, 16'hFF00, 0, 0, 2'b00, 4'd0, 16'h0);
    check("bw_part", 32'(rdata_a0), 32'h0000FF34);
    check("bw_wr_rvalid", 32'(rvalid_a0), 32'd1);
    access(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd3, 16'h0);
    check("bw_rd_b", 32'(rdata_b0), 32'h0000FF34);
    check("bw_rv", 32'({rvalid_a0, rvalid_b0}), 32'd1);

    // Overlapping same-address writes.
    access(1, 1, 2'b11, 4'd5, 16'h1111, 1, 1, 2'b01, 4'd5, 16'h2222);
    check("col_pulse", 32'(coll0), 32'd1);
    check("col_rd_a", 32'(rdata_a0), 32'h00001111);
    check("col_rd_b", 32'(rdata_b0), 32'h00001111);
    access(1, 0, 2'b00, 4'd5, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    check("col_stored", 32'(rdata_a0), 32'h00001111);
    check("col_clear", 32'(coll0), 32'd0);
    check("col_lat2", 32'(coll1), 32'd1);

    // Disjoint lanes from both ports.
    access(1, 1, 2'b10, 4'd6, 16'hAA00, 1, 1, 2'b01, 4'd6, 16'h00BB);
    check("part_coll", 32'(coll0), 32'd0);
    check("part_rd_a", 32'(rdata_a0), 32'h0000AABB);
    check("part_rd_b", 32'(rdata_b0), 32'h0000AABB);
    access(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd6, 16'h0);
    check("part_stored", 32'(rdata_b0), 32'h0000AABB);

    // Same-edge write/read forwarding, both latencies.
    idle();
    access(1, 1, 2'b11, 4'd7, 16'hBEEF, 1, 0, 2'b00, 4'd7, 16'h0);
    check("fwd_b", 32'(rdata_b0), 32'h0000BEEF);
    check("fwd_lat2_early", 32'(rvalid_b1), 32'd0);
    access(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd7, 16'h0);
    check("fwd_lat2_v", 32'(rvalid_b1), 32'd1);
    check("fwd_lat2_d", 32'(rdata_b1), 32'h0000BEEF);
    check("raw_next", 32'(rdata_b0), 32'h0000BEEF);
    idle();

    // Reset clears outputs at once; a mid-clear reset restarts the walk.
    rst_n = 1'b0;
    #1;
    check("rst2_rdata_b", 32'(rdata_b0), 32'd0);
    check("rst2_rdata_b1", 32'(rdata_b1), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy0), 32'd1);
    check("mid_rst_rv", 32'({rvalid_a0, rvalid_b0, coll0}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clear("clr2");
    for (int i = 0; i < 16; i++) begin
      access(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'(i), 16'h0);
      check($sformatf("clr2_rd%0d", i), 32'(rdata_b0), 32'h0000A5A5);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dpram_be.md
# dpram_be

Parametrised true-dual-port RAM on a single clock. It adds per-byte write enables, a deterministic cross-port collision policy, same-address read forwarding, an optional output register stage, and a hardware clear sequencer that runs after reset. It is the general video/ROM/shared-RAM building block for the IIgs core and replaces ad-hoc per-use dual-port arrays.

## Interface
- DATA_W, 16: word width; must be a multiple of BYTE_W.
- ADDR_W, 10: address width; depth = 2**ADDR_W.
- BYTE_W, 8: byte-lane width; NB = DATA_W/BYTE_W lanes.
- OUT_REG, 0: 1 adds an output register stage, making read latency 2.
- CLEAR_ON_RESET, 1: 1 runs the clear sequencer after reset.
- CLEAR_VALUE, 0: word written to every address during clear.

- clock  in  1  single clock for both ports.
- reset_n  in  1  asynchronous, active-low reset.
- busy  out  1  clear in progress; both ports ignored while high.
- en_a / en_b  in  1  access request on port A / B.
- we_a / we_b  in  1  write when set together with en_x.
- be_a / be_b  in  NB  byte-lane write enables; lane i = bits [i*BYTE_W +: BYTE_W].
- addr_a / addr_b  in  ADDR_W  word address.
- wdata_a / wdata_b  in  DATA_W  write data.
- rdata_a / rdata_b  out  DATA_W  read data.
- rvalid_a / rvalid_b  out  1  rdata_x valid this cycle.
- collision  out  1  one-cycle pulse on overlapping same-address writes.

## Operation
- FSM states are CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - In CLEAR, a counter starting at 0 writes CLEAR_VALUE to one address per cycle.
  - After address 2**ADDR_W-1 is written, the FSM moves to RUN.
  - Reset asserted mid-clear aborts the clear; the next release restarts it from address 0.
- In CLEAR, en_x is ignored: no writes, rvalid_x=0, rdata_x holds.
- Write with en_x & we_x: only lanes with be_x[i]=1 are updated. be_x=0 makes the access a read.
- A port's own access returns, through rdata_x, the post-write word: new bytes in enabled lanes, old bytes elsewhere (write-first).
- Same-address, both ports writing:
  - Lanes enabled on both ports take A's data.
  - Lanes enabled on only one port take that port's data.
  - collision=1 if any lane overlaps.
- Same address, one port writing and the other reading: the reader gets the post-write word (forwarded, not stale).
- rdata_x holds its last value when en_x=0.
- Memory contents are not reset; they are defined only after a clear or a write.

## Timing
- Reset values:
  - busy = CLEAR_ON_RESET.
  - rdata_a = rdata_b = 0.
  - rvalid_a = rvalid_b = 0.
  - collision = 0.
- Read latency:
  - OUT_REG=0: request at edge N, rdata/rvalid valid after edge N+1.
  - OUT_REG=1: valid after edge N+2.
  - The pipeline accepts one request per port per cycle.
- rvalid_x is high for exactly one cycle per accepted request, reads and writes alike.
- Clear duration:
  - busy stays high for exactly 2**ADDR_W cycles after reset release.
  - The first access is accepted on the edge where busy=0 is sampled.
  - rvalid stays 0 throughout the clear, including the OUT_REG flush.
- collision asserts in the same latency slot as rvalid for the colliding writes.
- Forwarding applies to same-edge requests only. A read issued one cycle after a write sees the stored array value, which is already updated.

## Structure
- Package dpram_pkg:
  - state enum {CLEAR, RUN}.
  - function merge_bytes(old, new, be) returning the lane-merged word.
  - function lane_overlap(be_a, be_b).
- Sub-module dpram_clear_seq: the FSM, address counter and busy. It outputs a clear write strobe and address, which are muxed onto port A's write path.
- Array storage, the port logic and the optional OUT_REG stage stay in dpram_be.

## Test plan
- Clear: ADDR_W=4, CLEAR_VALUE=16'hA5A5, release reset -> busy high 16 cycles; afterwards reads of addresses 0..15 all return A5A5 with rvalid one cycle later.
- Byte write: A writes 16'h1234 be=2'b11 to addr 3, then 16'hFF00 be=2'b10 to addr 3 -> the second write's rdata_a = 16'hFF34; a B read of addr 3 next cycle returns FF34.
- Collision: same edge, A writes 16'h1111 be=11 and B writes 16'h2222 be=01, both to addr 5 -> collision pulse; stored word 16'h1111.
- Partial overlap: A be=10 16'hAA00, B be=01 16'h00BB, same address -> stored 16'hAABB; collision=0.
- Forwarding: A writes 16'hBEEF to addr 7 while B reads addr 7 on the same edge -> rdata_b = BEEF. Repeat with OUT_REG=1 -> BEEF arrives at latency 2.
- Reset mid-clear: assert reset_n=0 at clear address 9 -> outputs return to reset values immediately; after release, busy lasts a full 2**ADDR_W cycles and all addresses read CLEAR_VALUE.
